// File: rtl/chip_tester_pkg.sv
// ---------------------------------------------------------------------------
// chip_tester_pkg
// Shared definitions for the chip test sequencer: FSM state encoding,
// default sizing parameters and the engine index assigned to each chip type
// on the tester board.
// ---------------------------------------------------------------------------
package chip_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ACK    = 3'd3,
    ST_NEXT   = 3'd4,
    ST_REPORT = 3'd5
  } state_e;

  localparam int N_CHIPS_DEF     = 8;
  localparam int SEL_W_DEF       = 3;
  localparam int TIMEOUT_CYC_DEF = 1024;

  // Engine slot of each supported device
  localparam int CHIP_7400N  = 0;
  localparam int CHIP_7404N  = 1;
  localparam int CHIP_7408N  = 2;
  localparam int CHIP_7432N  = 3;
  localparam int CHIP_7486N  = 4;
  localparam int CHIP_74157N = 5;
  localparam int CHIP_74161N = 6;
  localparam int CHIP_74193N = 7;

endpackage

// File: rtl/seq_timeout_ctr.sv
// ---------------------------------------------------------------------------
// seq_timeout_ctr
// Cycle counter bounding how long the sequencer waits on an engine.
// Ports:
//   Clk, Reset_n : clock, asynchronous active-low reset
//   i_clr        : synchronous clear (wins over i_en)
//   i_en         : count one per cycle
//   o_expired    : counter has reached TIMEOUT_CYC-1
// ---------------------------------------------------------------------------
module seq_timeout_ctr #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYC >= 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_cnt;

  // Holds at LAST so an unattended enable can never wrap back to zero
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/chip_test_sequencer.sv
// ---------------------------------------------------------------------------
// chip_test_sequencer
// Runs the attached chip test engines one at a time (single chip or all of
// them) and collects a per-engine pass bitmap plus an overall verdict.
// Ports:
//   Clk, Reset_n        : clock, asynchronous active-low reset
//   Start               : run request level, rising edge starts a run
//   Auto, Chip_sel      : test all engines / index for a single-engine run
//   Eng_done, Eng_rslt  : per-engine done and pass result
//   Eng_run, Eng_disp   : per-engine launch pulse and result acknowledge
//   Pin_sel             : socket pin-bus mux select (current engine index)
//   Busy, Done, Pass    : run in progress / run finished / overall verdict
//   Match, Timeout      : per-engine pass bitmap, sticky timeout flag
//   Dbg_state           : current FSM state
//
// Engine handshake: Eng_run[i] is a one-cycle launch request. The engine
// answers by raising Eng_done[i] with Eng_rslt[i] valid in the same cycle.
// The sequencer then holds Eng_disp[i] as acknowledge until the engine drops
// Eng_done[i]. Both waits are bounded by TIMEOUT_CYC cycles.
// ---------------------------------------------------------------------------
module chip_test_sequencer
  import chip_tester_pkg::*;
#(
  parameter int N_CHIPS     = N_CHIPS_DEF,
  parameter int SEL_W       = SEL_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic               Auto,
  input  logic [SEL_W-1:0]   Chip_sel,
  input  logic [N_CHIPS-1:0] Eng_done,
  input  logic [N_CHIPS-1:0] Eng_rslt,
  output logic [N_CHIPS-1:0] Eng_run,
  output logic [N_CHIPS-1:0] Eng_disp,
  output logic [SEL_W-1:0]   Pin_sel,
  output logic               Busy,
  output logic               Done,
  output logic               Pass,
  output logic [N_CHIPS-1:0] Match,
  output logic               Timeout,
  output state_e             Dbg_state
);

  state_e             r_state;
  state_e             w_next_state;
  logic               r_start_d;
  logic               r_start_edge;
  logic               r_auto;
  logic [SEL_W-1:0]   r_idx;
  logic [N_CHIPS-1:0] r_match;
  logic               r_pass;
  logic               r_timeout;

  logic [N_CHIPS-1:0] w_idx_oh;
  logic               w_sel_done;
  logic               w_sel_rslt;
  logic               w_sel_match;
  logic               w_sel_valid;
  logic               w_last;
  logic               w_tmr_clr;
  logic               w_tmr_en;
  logic               w_expired;

  // Out-of-range indices give an all-zero mask, so no engine is touched
  assign w_idx_oh    = N_CHIPS'(1) << r_idx;
  assign w_sel_done  = |(Eng_done & w_idx_oh);
  assign w_sel_rslt  = |(Eng_rslt & w_idx_oh);
  assign w_sel_match = |(r_match & w_idx_oh);
  assign w_sel_valid = (int'(Chip_sel) < N_CHIPS);
  assign w_last      = (int'(r_idx) >= N_CHIPS - 1);

  seq_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .o_expired (w_expired)
  );

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and timer control
  always_comb begin
    w_next_state = r_state;
    w_tmr_clr    = 1'b0;
    w_tmr_en     = 1'b0;
    case (r_state)
      ST_IDLE, ST_REPORT: begin
        if (r_start_edge) begin
          w_next_state = (Auto || w_sel_valid) ? ST_LAUNCH : ST_REPORT;
        end
      end
      ST_LAUNCH: begin
        w_tmr_clr    = 1'b1;
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        w_tmr_en = 1'b1;
        if (w_sel_done || w_expired) begin
          w_tmr_clr    = 1'b1;  // ACK starts with a fresh budget
          w_next_state = ST_ACK;
        end
      end
      ST_ACK: begin
        w_tmr_en = 1'b1;
        if (!w_sel_done || w_expired) begin
          w_next_state = ST_NEXT;
        end
      end
      ST_NEXT: begin
        w_next_state = (r_auto && !w_last) ? ST_LAUNCH : ST_REPORT;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Start edge detect and run datapath
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_start_d    <= 1'b1;  // Start held high across reset is not an edge
      r_start_edge <= 1'b0;
      r_auto       <= 1'b0;
      r_idx        <= '0;
      r_match      <= '0;
      r_pass       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_start_d    <= Start;
      r_start_edge <= Start & ~r_start_d;
      case (r_state)
        ST_IDLE, ST_REPORT: begin
          if (r_start_edge) begin
            r_match   <= '0;
            r_timeout <= 1'b0;
            r_pass    <= 1'b0;
            r_auto    <= Auto;
            r_idx     <= Auto ? '0 : Chip_sel;
          end
        end
        ST_WAIT: begin
          // Done wins over a timeout in the same cycle
          if (w_sel_done) begin
            r_match <= (r_match & ~w_idx_oh) | (w_sel_rslt ? w_idx_oh : '0);
          end else if (w_expired) begin
            r_match   <= r_match & ~w_idx_oh;
            r_timeout <= 1'b1;
          end
        end
        ST_NEXT: begin
          if (r_auto && !w_last) begin
            r_idx <= r_idx + SEL_W'(1);
          end else begin
            r_pass <= r_auto ? (|r_match) : w_sel_match;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign Eng_run   = (r_state == ST_LAUNCH) ? w_idx_oh : '0;
  assign Eng_disp  = (r_state == ST_ACK)    ? w_idx_oh : '0;
  assign Pin_sel   = r_idx;
  assign Busy      = (r_state != ST_IDLE) && (r_state != ST_REPORT);
  assign Done      = (r_state == ST_REPORT);
  assign Pass      = r_pass;
  assign Match     = r_match;
  assign Timeout   = r_timeout;
  assign Dbg_state = r_state;

endmodule
